// File: rtl/sblk_loader.sv
// Feeds one SuperBlock's per-tile weight/activation SRAM write ports from a serial word stream, round-robin over tiles.
// Optional broadcast load (every word to all tiles) under SBLK_LOADER_BCAST_EN, which adds cfg_sel[1] = cfg_bcast.
module sblk_loader #(
  parameter int NTILE       = 4,
  parameter int W_BIT       = 16,
  parameter int WADDR_BIT   = 10,
  parameter int ACT_BIT     = 16,
  parameter int ACTADDR_BIT = 6
) (
  input  logic                     clk_l,
  input  logic                     rst_n,
  input  logic                     cfg_start,
`ifdef SBLK_LOADER_BCAST_EN
  input  logic [1:0]               cfg_sel,
`else
  input  logic [0:0]               cfg_sel,
`endif
  input  logic [WADDR_BIT-1:0]     cfg_base,
  input  logic [WADDR_BIT-1:0]     cfg_depth,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W_BIT-1:0]         in_data,
  input  logic                     in_last,
  output logic [NTILE*W_BIT-1:0]   w_wr_data,
  output logic [NTILE-1:0]         w_wr_en,
  output logic [WADDR_BIT-1:0]     w_wr_addr,
  output logic [NTILE*ACT_BIT-1:0] act_wr_data,
  output logic [NTILE-1:0]         act_wr_en,
  output logic [ACTADDR_BIT-1:0]   act_wr_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int              TBIT      = $clog2(NTILE);
  localparam logic [TBIT-1:0] TILE_LAST = TBIT'(NTILE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_sel;
  logic [WADDR_BIT-1:0]     r_base;
  logic [WADDR_BIT-1:0]     r_depth;
  logic [WADDR_BIT-1:0]     r_cnt_addr;
  logic [TBIT-1:0]          r_cnt_tile;
  logic [NTILE*W_BIT-1:0]   r_w_data;
  logic [NTILE-1:0]         r_w_en;
  logic [WADDR_BIT-1:0]     r_w_addr;
  logic [NTILE*ACT_BIT-1:0] r_act_data;
  logic [NTILE-1:0]         r_act_en;
  logic [ACTADDR_BIT-1:0]   r_act_addr;
  logic                     r_done;
  logic                     r_err;
  logic                     w_start;
  logic                     w_hs;
  logic                     w_bcast;
  logic                     w_final;

`ifdef SBLK_LOADER_BCAST_EN
  logic r_bcast;
  assign w_bcast = r_bcast;
`else
  assign w_bcast = 1'b0;
`endif

  // Handshake decoded from state directly so it never loops through the in_ready logic.
  assign w_start = (r_state == S_IDLE) && cfg_start;
  assign w_hs    = (r_state == S_LOAD) && in_valid;
  assign w_final = (r_cnt_addr == r_depth) && (w_bcast || (r_cnt_tile == TILE_LAST));

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_hs && (w_final || in_last)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      r_sel      <= 1'b0;
      r_base     <= '0;
      r_depth    <= '0;
      r_cnt_addr <= '0;
      r_cnt_tile <= '0;
      r_w_data   <= '0;
      r_w_en     <= '0;
      r_w_addr   <= '0;
      r_act_data <= '0;
      r_act_en   <= '0;
      r_act_addr <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef SBLK_LOADER_BCAST_EN
      r_bcast    <= 1'b0;
`endif
    end else begin
      r_w_en   <= '0;
      r_act_en <= '0;
      r_done   <= (r_state == S_DONE);

      if (w_start) begin
        r_sel      <= cfg_sel[0];
        r_base     <= cfg_base;
        r_depth    <= cfg_depth;
        r_cnt_addr <= '0;
        r_cnt_tile <= '0;
        r_err      <= 1'b0;
`ifdef SBLK_LOADER_BCAST_EN
        r_bcast    <= cfg_sel[1];
`endif
      end

      if (w_hs) begin
        if (w_bcast || (r_cnt_tile == TILE_LAST)) begin
          r_cnt_tile <= '0;
          r_cnt_addr <= r_cnt_addr + 1'b1;
        end else begin
          r_cnt_tile <= r_cnt_tile + 1'b1;
        end

        // Covers both an early in_last and a final word that arrives without in_last.
        if (w_final != in_last) r_err <= 1'b1;

        if (!r_sel) begin
          r_w_addr <= r_base + r_cnt_addr;
        end else begin
          r_act_addr <= r_base[ACTADDR_BIT-1:0] + r_cnt_addr[ACTADDR_BIT-1:0];
        end

        for (int t = 0; t < NTILE; t++) begin
          if (w_bcast || (r_cnt_tile == TBIT'(t))) begin
            if (!r_sel) begin
              r_w_en[t]                   <= 1'b1;
              r_w_data[t*W_BIT +: W_BIT]  <= in_data;
            end else begin
              r_act_en[t]                      <= 1'b1;
              r_act_data[t*ACT_BIT +: ACT_BIT] <= in_data[ACT_BIT-1:0];
            end
          end
        end
      end
    end
  end

  assign w_wr_data   = r_w_data;
  assign w_wr_en     = r_w_en;
  assign w_wr_addr   = r_w_addr;
  assign act_wr_data = r_act_data;
  assign act_wr_en   = r_act_en;
  assign act_wr_addr = r_act_addr;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_sblk_loader.sv
// Randomised bench for sblk_loader: every observed SRAM write is compared against a per-word tile/address model.
module tb_sblk_loader;
  localparam int NT = 4;
  localparam int WB = 16;
  localparam int WA = 10;
  localparam int AB = 16;
  localparam int AA = 6;

  logic clk_l;
  logic rst_n;
  logic cfg_start;
`ifdef SBLK_LOADER_BCAST_EN
  logic [1:0] cfg_sel;
`else
  logic cfg_sel;
`endif
  logic [WA-1:0]    cfg_base;
  logic [WA-1:0]    cfg_depth;
  logic             in_valid;
  logic             in_ready;
  logic [WB-1:0]    in_data;
  logic             in_last;
  logic [NT*WB-1:0] w_wr_data;
  logic [NT-1:0]    w_wr_en;
  logic [WA-1:0]    w_wr_addr;
  logic [NT*AB-1:0] act_wr_data;
  logic [NT-1:0]    act_wr_en;
  logic [AA-1:0]    act_wr_addr;
  logic             busy;
  logic             done;
  logic             err;

  sblk_loader #(.NTILE(NT), .W_BIT(WB), .WADDR_BIT(WA), .ACT_BIT(AB), .ACTADDR_BIT(AA)) dut (
    .clk_l(clk_l), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_sel(cfg_sel),
    .cfg_base(cfg_base), .cfg_depth(cfg_depth), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .w_wr_data(w_wr_data), .w_wr_en(w_wr_en),
    .w_wr_addr(w_wr_addr), .act_wr_data(act_wr_data), .act_wr_en(act_wr_en),
    .act_wr_addr(act_wr_addr), .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int mon_viol = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_hs_cyc = 0;
  int ncyc = 0;
  logic hs_q = 1'b0;
  logic bcast_mode = 1'b0;
  logic [40:0] obs[$];
  logic [40:0] exp_q[$];
  logic [15:0] tx[$];

  initial begin
    clk_l = 1'b0;
    forever #5 clk_l = ~clk_l;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [40:0] mk(input logic s, input int t, input int a, input logic [15:0] d);
    return {s, t[7:0], a[15:0], d};
  endfunction

  // Reference: word k lands on tile k mod NT at base + k/NT (or on every tile at base + k when broadcasting).
  function automatic void build_model(input logic s, input logic bc, input int base, input int n);
    int amod;
    amod = s ? (1 << AA) : (1 << WA);
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      if (bc) begin
        for (int t = 0; t < NT; t++) exp_q.push_back(mk(s, t, (base + k) % amod, tx[k]));
      end else begin
        exp_q.push_back(mk(s, k % NT, (base + k / NT) % amod, tx[k]));
      end
    end
  endfunction

  // Write monitor: enables seen at a negedge belong to the handshake sampled one negedge earlier.
  initial begin
    forever begin
      @(negedge clk_l);
      ncyc++;
      if (!rst_n) begin
        hs_q = 1'b0;
      end else begin
        if (((w_wr_en | act_wr_en) != '0) !== hs_q) mon_viol++;
        if (hs_q && !bcast_mode && ($countones(w_wr_en) + $countones(act_wr_en)) != 1) mon_viol++;
        for (int t = 0; t < NT; t++) begin
          if (w_wr_en[t])   obs.push_back(mk(1'b0, t, int'(w_wr_addr), w_wr_data[t*WB +: WB]));
          if (act_wr_en[t]) obs.push_back(mk(1'b1, t, int'(act_wr_addr), act_wr_data[t*AB +: AB]));
        end
        if (done) begin
          done_cnt++;
          done_cyc = ncyc;
        end
        hs_q = in_valid && in_ready;
        if (hs_q) last_hs_cyc = ncyc;
      end
    end
  end

  task automatic step;
    @(posedge clk_l);
    #1;
  endtask

  task automatic clear_mon;
    obs.delete();
    mon_viol = 0;
    done_cnt = 0;
  endtask

  task automatic do_load(input logic sel, input logic bc, input int base, input int depth,
                         input int n, input int last_at, input int stall_pct, input bit start_on_last);
    bcast_mode = bc;
`ifdef SBLK_LOADER_BCAST_EN
    cfg_sel = {bc, sel};
`else
    cfg_sel = sel;
`endif
    cfg_base  = WA'(base);
    cfg_depth = WA'(depth);
    cfg_start = 1'b1;
    step;
    cfg_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      for (int s = 0; s < 8 && int'($urandom_range(99)) < stall_pct; s++) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'($urandom);
        step;
      end
      in_valid = 1'b1;
      in_data  = tx[k];
      in_last  = (k == last_at);
      if (start_on_last && k == n - 1) begin
        cfg_start = 1'b1;
        cfg_sel   = ~cfg_sel;
      end
      step;
      cfg_start = 1'b0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (4) step;
    bcast_mode = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) step;
    for (int p = 0; p < 2; p++) begin
      checks++; if (w_wr_en !== '0) begin errors++; $display("FAIL rst_w_wr_en: got %b expected 0", w_wr_en); end
      checks++; if (act_wr_en !== '0) begin errors++; $display("FAIL rst_act_wr_en: got %b expected 0", act_wr_en); end
      checks++; if (w_wr_addr !== '0) begin errors++; $display("FAIL rst_w_wr_addr: got %h expected 0", w_wr_addr); end
      checks++; if (act_wr_addr !== '0) begin errors++; $display("FAIL rst_act_wr_addr: got %h expected 0", act_wr_addr); end
      checks++; if (w_wr_data !== '0) begin errors++; $display("FAIL rst_w_wr_data: got %h expected 0", w_wr_data); end
      checks++; if (act_wr_data !== '0) begin errors++; $display("FAIL rst_act_wr_data: got %h expected 0", act_wr_data); end
      checks++; if ({busy, done, err, in_ready} !== 4'b0) begin errors++; $display("FAIL rst_status: got busy/done/err/rdy=%b expected 0000", {busy, done, err, in_ready}); end
      rst_n = 1'b1;
      step;
    end
  endtask

  task automatic test_weight_basic;
    clear_mon();
    tx.delete();
    for (int k = 0; k < 8; k++) tx.push_back(16'(k + 1));
    do_load(1'b0, 1'b0, 'h010, 1, 8, 7, 0, 1'b0);
    build_model(1'b0, 1'b0, 'h010, 8);
    checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL wt_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL wt_write[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    checks++; if (mon_viol !== 0) begin errors++; $display("FAIL wt_enables: got %0d bad cycles expected 0", mon_viol); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL wt_done_cnt: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc - last_hs_cyc !== 2) begin errors++; $display("FAIL wt_done_lat: got %0d expected 2", done_cyc - last_hs_cyc); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wt_err: got %b expected 0", err); end
  endtask

  task automatic test_act_wrap;
    clear_mon();
    tx.delete();
    for (int k = 0; k < 12; k++) tx.push_back(16'($urandom));
    do_load(1'b1, 1'b0, 62, 2, 12, 11, 0, 1'b0);
    build_model(1'b1, 1'b0, 62, 12);
    checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL act_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL act_write[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    checks++; if (mon_viol !== 0) begin errors++; $display("FAIL act_enables: got %0d bad cycles expected 0", mon_viol); end
    checks++; if (err !== 1'b0 || done_cnt !== 1) begin errors++; $display("FAIL act_end: got err=%b done_cnt=%0d expected 0/1", err, done_cnt); end
  endtask

  task automatic test_stalls;
    int base;
    for (int r = 0; r < 3; r++) begin
      clear_mon();
      tx.delete();
      base = int'($urandom_range(1023));
      for (int k = 0; k < 12; k++) tx.push_back(16'($urandom));
      do_load(1'b0, 1'b0, base, 2, 12, 11, 50, 1'b0);
      build_model(1'b0, 1'b0, base, 12);
      checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d expected %0d", obs.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
        checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL stall_write[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end
      end
      checks++; if (mon_viol !== 0) begin errors++; $display("FAIL stall_enables: got %0d bad cycles expected 0", mon_viol); end
      checks++; if (err !== 1'b0 || done_cnt !== 1) begin errors++; $display("FAIL stall_end: got err=%b done_cnt=%0d expected 0/1", err, done_cnt); end
    end
  endtask

  task automatic test_early_last;
    clear_mon();
    tx.delete();
    for (int k = 0; k < 5; k++) tx.push_back(16'($urandom));
    do_load(1'b0, 1'b0, 'h100, 1, 5, 4, 0, 1'b0);
    build_model(1'b0, 1'b0, 'h100, 5);
    checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL early_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL early_write[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL early_err: got %b expected 1", err); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL early_done: got %0d expected 1", done_cnt); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL early_idle: got rdy=%b busy=%b expected 0/0", in_ready, busy); end

    clear_mon();
    tx.delete();
    for (int k = 0; k < 4; k++) tx.push_back(16'($urandom));
    do_load(1'b0, 1'b0, 'h200, 0, 4, -1, 0, 1'b0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL nolast_err: got %b expected 1", err); end
    checks++; if (done_cnt !== 1 || obs.size() !== 4) begin errors++; $display("FAIL nolast_end: got done_cnt=%0d writes=%0d expected 1/4", done_cnt, obs.size()); end

    cfg_sel   = '0;
    cfg_depth = '0;
    cfg_start = 1'b1;
    step;
    cfg_start = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL err_clear_busy: got %b expected 1", busy); end
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(k);
      in_last  = (k == 3);
      step;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (4) step;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_after_good: got %b expected 0", err); end
  endtask

  task automatic test_reset_mid;
    clear_mon();
    cfg_sel   = '0;
    cfg_base  = WA'('h020);
    cfg_depth = WA'(3);
    cfg_start = 1'b1;
    step;
    cfg_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      in_last  = 1'b0;
      step;
    end
    checks++; if (w_wr_en !== 4'b0100) begin errors++; $display("FAIL midrst_pre: got %b expected 0100", w_wr_en); end
    rst_n = 1'b0;
    #1;
    checks++; if (w_wr_en !== '0 || act_wr_en !== '0) begin errors++; $display("FAIL midrst_en: got %b/%b expected 0/0", w_wr_en, act_wr_en); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL midrst_busy: got busy=%b rdy=%b expected 0/0", busy, in_ready); end
    in_valid = 1'b0;
    step;
    rst_n = 1'b1;
    step;

    clear_mon();
    tx.delete();
    for (int k = 0; k < 4; k++) tx.push_back(16'($urandom));
    do_load(1'b0, 1'b0, 'h055, 0, 4, 3, 0, 1'b0);
    build_model(1'b0, 1'b0, 'h055, 4);
    checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL postrst_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL postrst_write[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    checks++; if (err !== 1'b0 || done_cnt !== 1) begin errors++; $display("FAIL postrst_end: got err=%b done_cnt=%0d expected 0/1", err, done_cnt); end
  endtask

  task automatic test_back_to_back;
    int base;
    clear_mon();
    tx.delete();
    base = int'($urandom_range(1023));
    for (int k = 0; k < 8; k++) tx.push_back(16'($urandom));
    do_load(1'b0, 1'b0, base, 1, 8, 7, 0, 1'b1);
    build_model(1'b0, 1'b0, base, 8);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_ignored_start: got busy=%b expected 0", busy); end
    checks++; if (done_cnt !== 1 || obs.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_first: got done_cnt=%0d writes=%0d expected 1/%0d", done_cnt, obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_write[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end
    end

    clear_mon();
    tx.delete();
    base = int'($urandom_range(63));
    for (int k = 0; k < 8; k++) tx.push_back(16'($urandom));
    do_load(1'b1, 1'b0, base, 1, 8, 7, 25, 1'b0);
    build_model(1'b1, 1'b0, base, 8);
    checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL b2b2_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL b2b2_write[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    checks++; if (mon_viol !== 0 || err !== 1'b0) begin errors++; $display("FAIL b2b2_end: got viol=%0d err=%b expected 0/0", mon_viol, err); end
  endtask

`ifdef SBLK_LOADER_BCAST_EN
  task automatic test_bcast;
    int base;
    clear_mon();
    tx.delete();
    base = int'($urandom_range(1023));
    for (int k = 0; k < 4; k++) tx.push_back(16'($urandom));
    do_load(1'b0, 1'b1, base, 3, 4, 3, 0, 1'b0);
    build_model(1'b0, 1'b1, base, 4);
    checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL bc_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL bc_write[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    checks++; if (done_cnt !== 1 || err !== 1'b0) begin errors++; $display("FAIL bc_end: got done_cnt=%0d err=%b expected 1/0", done_cnt, err); end
    checks++; if (done_cyc - last_hs_cyc !== 2) begin errors++; $display("FAIL bc_done_lat: got %0d expected 2", done_cyc - last_hs_cyc); end
  endtask
`endif

  initial begin
    cfg_start = 1'b0;
    cfg_sel   = '0;
    cfg_base  = '0;
    cfg_depth = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    test_reset();
    test_weight_basic();
    test_act_wrap();
    test_stalls();
    test_early_last();
    test_reset_mid();
    test_back_to_back();
`ifdef SBLK_LOADER_BCAST_EN
    test_bcast();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
